wb_hyperram_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single `wrapped_wb_hyperram` slave port between the management SoC bus (master 0) and a secondary user-side master (master 1, e.g. a DMA or LA-driven test engine). It sits in `user_project_wrapper` between the masters and the HyperRAM slave. It grants the port round-robin, holds a grant for a whole `cyc` cycle, and aborts a transfer with a sticky error flag if the slave stops acknowledging.

---
 rtl/wb_hyperram_pkg.sv | 29 ++
 rtl/wb_hyperram_arbiter_timeout.sv | 34 +++
 rtl/wb_hyperram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_wb_hyperram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_hyperram_pkg.sv
// Shared types for the two-master HyperRAM Wishbone arbiter.
// State encoding, bus bundles and the default abort read data.
package wb_hyperram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GNT0,
    ST_GNT1,
    ST_ABORT0,
    ST_ABORT1
  } arb_state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] dat;
  } wb_rsp_t;

  localparam logic [31:0] ABORT_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_hyperram_arbiter_timeout.sv
// Stall watchdog: counts strobe cycles without an ack.
// Expires when the count reaches the limit and the slave is still silent.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_W-1:0] ONE   = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Restart on a new grant, on any ack, or while no strobe is pending.
  always_comb begin
    cnt_d = cnt_q + ONE;
    if (start_i || !stb_i || ack_i) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LIMIT) && stb_i && !ack_i;

endmodule

// File: rtl/wb_hyperram_arbiter.sv
// Round-robin two-master Wishbone arbiter for the HyperRAM slave.
// Holds a grant for a whole cyc, aborts stalled strobes with a sticky flag.
module wb_hyperram_arbiter
  import wb_hyperram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8,
  parameter logic [31:0] ABORT_DATA     = ABORT_DATA_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic        timeout_flag_o,
  input  logic        timeout_clr_i,
  output logic [1:0]  grant_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       flag_q, flag_d;
  logic       expired;
  logic       start;
  logic       set_flag;
  wb_req_t    m0_req, m1_req, s_req;
  wb_rsp_t    m0_rsp, m1_rsp;

  assign m0_req = '{m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
  assign m1_req = '{m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};

  assign start = (state_d == ST_GNT0 && state_q != ST_GNT0)
              || (state_d == ST_GNT1 && state_q != ST_GNT1);

  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_tmo (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .start_i   (start),
    .stb_i     (s_stb_o),
    .ack_i     (s_ack_i),
    .expired_o (expired)
  );

  // State, round-robin history and sticky timeout flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      flag_q  <= flag_d;
    end
  end

  // Next state: arbitrate in IDLE, hold for the cyc, abort on stall.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? ST_GNT0 : ST_GNT1;
        else if (m0_cyc_i)        state_d = ST_GNT0;
        else if (m1_cyc_i)        state_d = ST_GNT1;
      end
      ST_GNT0: begin
        if (!m0_cyc_i) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end else if (expired) begin
          state_d = ST_ABORT0;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end else if (expired) begin
          state_d = ST_ABORT1;
        end
      end
      ST_ABORT0: begin
        state_d = m0_cyc_i ? ST_GNT0 : ST_IDLE;
        if (!m0_cyc_i) last_d = 1'b0;
      end
      ST_ABORT1: begin
        state_d = m1_cyc_i ? ST_GNT1 : ST_IDLE;
        if (!m1_cyc_i) last_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flag set wins over clear, whether the clear lands entering or in the abort.
  always_comb begin
    set_flag = (state_d == ST_ABORT0) || (state_d == ST_ABORT1)
            || (state_q == ST_ABORT0) || (state_q == ST_ABORT1);
    flag_d   = flag_q;
    if (timeout_clr_i) flag_d = 1'b0;
    if (set_flag)      flag_d = 1'b1;
  end

  // Output muxing: owner is passed through, abort answers locally.
  always_comb begin
    s_req   = '0;
    m0_rsp  = '0;
    m1_rsp  = '0;
    grant_o = 2'b00;
    unique case (state_q)
      ST_GNT0: begin
        s_req   = m0_req;
        m0_rsp  = '{s_ack_i, s_dat_i};
        grant_o = 2'b01;
      end
      ST_GNT1: begin
        s_req   = m1_req;
        m1_rsp  = '{s_ack_i, s_dat_i};
        grant_o = 2'b10;
      end
      ST_ABORT0: begin
        m0_rsp  = '{1'b1, ABORT_DATA};
        grant_o = 2'b01;
      end
      ST_ABORT1: begin
        m1_rsp  = '{1'b1, ABORT_DATA};
        grant_o = 2'b10;
      end
      default: ;
    endcase
  end

  assign s_cyc_o        = s_req.cyc;
  assign s_stb_o        = s_req.stb;
  assign s_we_o         = s_req.we;
  assign s_sel_o        = s_req.sel;
  assign s_adr_o        = s_req.adr;
  assign s_dat_o        = s_req.dat;
  assign m0_ack_o       = m0_rsp.ack;
  assign m0_dat_o       = m0_rsp.dat;
  assign m1_ack_o       = m1_rsp.ack;
  assign m1_dat_o       = m1_rsp.dat;
  assign timeout_flag_o = flag_q;

endmodule

// File: tb/tb_wb_hyperram_arbiter.sv
// Directed self-checking bench for wb_hyperram_arbiter.
// Inputs change 1ns after posedge, outputs are sampled 2-3ns later.
module tb_wb_hyperram_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_wdat;
  logic        m0_ack;
  logic [31:0] m0_rdat;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_wdat;
  logic        m1_ack;
  logic [31:0] m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic        s_ack;
  logic [31:0] s_rdat;
  logic        flag, clr;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;

  wb_hyperram_arbiter #(
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_W      (8),
    .ABORT_DATA     (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .m0_cyc_i       (m0_cyc),
    .m0_stb_i       (m0_stb),
    .m0_we_i        (m0_we),
    .m0_sel_i       (m0_sel),
    .m0_adr_i       (m0_adr),
    .m0_dat_i       (m0_wdat),
    .m0_ack_o       (m0_ack),
    .m0_dat_o       (m0_rdat),
    .m1_cyc_i       (m1_cyc),
    .m1_stb_i       (m1_stb),
    .m1_we_i        (m1_we),
    .m1_sel_i       (m1_sel),
    .m1_adr_i       (m1_adr),
    .m1_dat_i       (m1_wdat),
    .m1_ack_o       (m1_ack),
    .m1_dat_o       (m1_rdat),
    .s_cyc_o        (s_cyc),
    .s_stb_o        (s_stb),
    .s_we_o         (s_we),
    .s_sel_o        (s_sel),
    .s_adr_o        (s_adr),
    .s_dat_o        (s_wdat),
    .s_ack_i        (s_ack),
    .s_dat_i        (s_rdat),
    .timeout_flag_o (flag),
    .timeout_clr_i  (clr),
    .grant_o        (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got=%b exp=00", grant); end
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rst_s_cyc got=%b exp=0", s_cyc); end
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL rst_s_stb got=%b exp=0", s_stb); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL rst_m0_ack got=%b exp=0", m0_ack); end
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL rst_m1_ack got=%b exp=0", m1_ack); end
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL rst_flag got=%b exp=0", flag); end
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    tick;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0;
    m0_sel = 4'hF; m0_adr = 32'h0000_0010;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_idle_grant got=%b exp=00", grant); end
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rd_idle_s_cyc got=%b exp=0", s_cyc); end
    tick;
    #2;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rd_grant got=%b exp=01", grant); end
    checks++; if (s_cyc !== 1'b1 || s_stb !== 1'b1) begin errors++; $display("FAIL rd_s_cycstb got=%b%b exp=11", s_cyc, s_stb); end
    checks++; if (s_adr !== 32'h10) begin errors++; $display("FAIL rd_s_adr got=%h exp=00000010", s_adr); end
    tick;
    #2;
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL rd_early_ack got=%b exp=0", m0_ack); end
    tick;
    tick;
    s_ack = 1'b1; s_rdat = 32'h1234_5678;
    m0_cyc = 1'b0; m0_stb = 1'b0;
    #2;
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got=%b exp=1", m0_ack); end
    checks++; if (m0_rdat !== 32'h1234_5678) begin errors++; $display("FAIL rd_dat got=%h exp=12345678", m0_rdat); end
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL rd_m1_ack got=%b exp=0", m1_ack); end
    checks++; if (m1_rdat !== 32'h0) begin errors++; $display("FAIL rd_m1_dat got=%h exp=00000000", m1_rdat); end
    tick;
    s_ack = 1'b0; s_rdat = '0;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_release got=%b exp=00", grant); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL rd_post_ack got=%b exp=0", m0_ack); end
  endtask

  task automatic test_tie;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h200;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_idle got=%b exp=00", grant); end
    tick;
    s_ack = 1'b1;
    m0_cyc = 1'b0; m0_stb = 1'b0;
    #2;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_first got=%b exp=01", grant); end
    checks++; if (s_adr !== 32'h100) begin errors++; $display("FAIL tie_first_adr got=%h exp=00000100", s_adr); end
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL tie_first_ack got=%b%b exp=01", m1_ack, m0_ack); end
    tick;
    s_ack = 1'b0;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_gap got=%b exp=00", grant); end
    tick;
    s_ack = 1'b1;
    m1_cyc = 1'b0; m1_stb = 1'b0;
    #2;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie_second got=%b exp=10", grant); end
    checks++; if (s_adr !== 32'h200) begin errors++; $display("FAIL tie_second_adr got=%h exp=00000200", s_adr); end
    checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL tie_second_ack got=%b%b exp=10", m1_ack, m0_ack); end
    tick;
    s_ack = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie2_idle got=%b exp=00", grant); end
    tick;
    #2;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie2_grant got=%b exp=01", grant); end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie2_release got=%b exp=00", grant); end
  endtask

  task automatic test_grant_hold;
    tick;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h300;
    #2;
    tick;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h400;
    s_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick;
      s_rdat = 32'hA0 + 32'(i);
      if (i == 3) begin
        m1_cyc = 1'b0; m1_stb = 1'b0;
      end
      #2;
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL hold_grant beat=%0d got=%b exp=10", i, grant); end
      checks++; if (m1_ack !== 1'b1) begin errors++; $display("FAIL hold_m1_ack beat=%0d got=%b exp=1", i, m1_ack); end
      checks++; if (m1_rdat !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL hold_m1_dat beat=%0d got=%h exp=%h", i, m1_rdat, 32'hA0 + 32'(i)); end
      checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL hold_m0_ack beat=%0d got=%b exp=0", i, m0_ack); end
    end
    tick;
    s_ack = 1'b0; s_rdat = '0;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL hold_gap got=%b exp=00", grant); end
    tick;
    #2;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL hold_next got=%b exp=01", grant); end
    checks++; if (s_adr !== 32'h400) begin errors++; $display("FAIL hold_next_adr got=%h exp=00000400", s_adr); end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL hold_release got=%b exp=00", grant); end
  endtask

  task automatic test_timeout;
    tick;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h500;
    #2;
    tick;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick;
      #2;
      checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL tmo_wait cyc=%0d got=%b exp=0", i, m0_ack); end
      checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL tmo_wait_cyc cyc=%0d got=%b exp=1", i, s_cyc); end
    end
    tick;
    s_ack = 1'b1; s_rdat = 32'h55AA_55AA;
    #2;
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL tmo_ack got=%b exp=1", m0_ack); end
    checks++; if (m0_rdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tmo_dat got=%h exp=deadbeef", m0_rdat); end
    checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin errors++; $display("FAIL tmo_s_cycstb got=%b%b exp=00", s_cyc, s_stb); end
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL tmo_flag got=%b exp=1", flag); end
    tick;
    s_ack = 1'b0; s_rdat = '0;
    #2;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tmo_regrant got=%b exp=01", grant); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL tmo_post_ack got=%b exp=0", m0_ack); end
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL tmo_flag_hold got=%b exp=1", flag); end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick;
    #2;
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL tmo_flag_idle got=%b exp=1", flag); end
    clr = 1'b1;
    tick;
    clr = 1'b0;
    #2;
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL tmo_flag_clr got=%b exp=0", flag); end
  endtask

  task automatic test_flag_priority;
    tick;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h700;
    tick;
    for (int i = 0; i < 5; i++) tick;
    clr = 1'b1;
    m0_cyc = 1'b0; m0_stb = 1'b0;
    #2;
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL prio_abort got=%b exp=1", m0_ack); end
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL prio_flag_abort got=%b exp=1", flag); end
    tick;
    clr = 1'b0;
    #2;
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL prio_flag_kept got=%b exp=1", flag); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL prio_idle got=%b exp=00", grant); end
    clr = 1'b1;
    tick;
    clr = 1'b0;
    #2;
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL prio_flag_clr got=%b exp=0", flag); end
  endtask

  task automatic test_reset_mid;
    tick;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h600;
    #2;
    tick;
    s_ack = 1'b1; s_rdat = 32'hCAFE_0001;
    #1;
    checks++; if (grant !== 2'b10 || m1_ack !== 1'b1) begin errors++; $display("FAIL rmid_pre got=%b/%b exp=10/1", grant, m1_ack); end
    rst = 1'b1;
    #1;
    checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin errors++; $display("FAIL rmid_s_cycstb got=%b%b exp=00", s_cyc, s_stb); end
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL rmid_m1_ack got=%b exp=0", m1_ack); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_grant got=%b exp=00", grant); end
    m1_cyc = 1'b0; m1_stb = 1'b0;
    s_ack = 1'b0; s_rdat = '0;
    tick;
    rst = 1'b0;
    tick;
    #2;
    checks++; if (grant !== 2'b00 || s_cyc !== 1'b0) begin errors++; $display("FAIL rmid_after got=%b/%b exp=00/0", grant, s_cyc); end
  endtask

  initial begin
    rst = 1'b1;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    m0_sel = '0; m0_adr = '0; m0_wdat = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    m1_sel = '0; m1_adr = '0; m1_wdat = '0;
    s_ack = 1'b0; s_rdat = '0;
    clr = 1'b0;
    test_reset;
    test_single_read;
    test_tie;
    test_grant_hold;
    test_timeout;
    test_flag_priority;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
